// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: iteration sequencer for a single cordic_stage instance.
// Captures an (x,y,z) operand set on start, drives the stage for N_ITER
// micro-rotations (shift count = iteration index, atan constant from ROM),
// feeds stage results back as the next operands, and returns the final vector
// with a one-cycle done pulse.
// Optional feature macro: CORDIC_GAIN_COMP_EN adds a GAIN state that scales
// the final x/y by ~0.6074 before they are presented.
//
// Handshake: start is a single-cycle request qualified by !busy. A request is
// accepted on the rising edge where start=1 and the controller is idle; any
// start seen while busy=1 is dropped (there is no queue). done pulses for one
// cycle with x_out/y_out/z_out valid, and those results hold until the next
// operation completes or reset.
module cordic_iter_ctrl #(
  parameter int N_ITER    = 8,
  parameter int STAGE_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] x_in,
  input  logic [8:0] y_in,
  input  logic [8:0] z_in,
  output logic [8:0] stg_x,
  output logic [8:0] stg_y,
  output logic [8:0] stg_z,
  output logic [8:0] stg_mem,
  output logic [2:0] stg_count,
  input  logic [8:0] stg_xout,
  input  logic [8:0] stg_yout,
  input  logic [8:0] stg_zout,
  output logic       busy,
  output logic       done,
  output logic [8:0] x_out,
  output logic [8:0] y_out,
  output logic [8:0] z_out,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAIN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] LAST_ITER = 3'(N_ITER - 1);
  localparam logic [1:0] LAT       = 2'(STAGE_LAT);

  state_t     state;
  state_t     state_next;
  logic [2:0] iter;
  logic [1:0] wait_cnt;
  logic [8:0] op_x;
  logic [8:0] op_y;
  logic [8:0] op_z;
  logic       capture;
  logic       last_iter;

  // atan(2^-i) in units where 128 LSB = 90 degrees
  function automatic logic [8:0] atan_rom(input logic [2:0] i);
    case (i)
      3'd0:    atan_rom = 9'd64;
      3'd1:    atan_rom = 9'd38;
      3'd2:    atan_rom = 9'd20;
      3'd3:    atan_rom = 9'd10;
      3'd4:    atan_rom = 9'd5;
      3'd5:    atan_rom = 9'd3;
      default: atan_rom = 9'd1;
    endcase
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  // Multiply by ~0.6074 with arithmetic shifts; result truncated to 9 bits
  function automatic logic [8:0] gain_scale(input logic [8:0] v);
    logic signed [8:0] s;
    s = v;
    gain_scale = (s >>> 1) + (s >>> 3) - (s >>> 6) - (s >>> 9);
  endfunction
`endif

  // The stage result is taken once it has had STAGE_LAT cycles to settle
  assign capture   = (state == RUN) && (wait_cnt == LAT);
  assign last_iter = (iter == LAST_ITER);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and stage-facing outputs (zero outside RUN)
  always_comb begin
    state_next = state;
    stg_x      = 9'd0;
    stg_y      = 9'd0;
    stg_z      = 9'd0;
    stg_mem    = 9'd0;
    stg_count  = 3'd0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        stg_x     = op_x;
        stg_y     = op_y;
        stg_z     = op_z;
        stg_mem   = atan_rom(iter);
        stg_count = iter;
        if (capture && last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_next = GAIN;
`else
          state_next = DONE;
`endif
        end
      end
      GAIN:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, feedback, iteration counting and result registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      iter     <= 3'd0;
      wait_cnt <= 2'd0;
      op_x     <= 9'd0;
      op_y     <= 9'd0;
      op_z     <= 9'd0;
      x_out    <= 9'd0;
      y_out    <= 9'd0;
      z_out    <= 9'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_x     <= x_in;
            op_y     <= y_in;
            op_z     <= z_in;
            iter     <= 3'd0;
            wait_cnt <= 2'd0;
          end
        end
        RUN: begin
          if (capture) begin
            op_x     <= stg_xout;
            op_y     <= stg_yout;
            op_z     <= stg_zout;
            wait_cnt <= 2'd0;
            // Wrap to 0 after the last rotation so the count never exceeds N_ITER-1
            iter     <= last_iter ? 3'd0 : iter + 3'd1;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: begin
          op_x <= gain_scale(op_x);
          op_y <= gain_scale(op_y);
        end
`endif
        DONE: begin
          x_out <= op_x;
          y_out <= op_y;
          z_out <= op_z;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
